// File: rtl/sprite_line_scheduler_if.sv
// Sprite scheduler bus: CPU table writes, raster timing
// and the per-pixel sprite hit returned to the video path.
interface sprite_line_scheduler_if #(
  parameter int IW = 3
);
  logic          cpu_we;
  logic [4:0]    cpu_addr;
  logic [7:0]    cpu_data;
  logic          line_start;
  logic [7:0]    raster_x;
  logic [7:0]    raster_y;
  logic          sprite_active;
  logic [IW-1:0] sprite_index;
  logic [7:0]    sprite_address;
  logic          line_overflow;
  logic          scan_busy;

  modport master (
    output cpu_we, cpu_addr, cpu_data,
    output line_start, raster_x, raster_y,
    input  sprite_active, sprite_index,
    input  sprite_address, line_overflow,
    input  scan_busy
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data,
    input  line_start, raster_x, raster_y,
    output sprite_active, sprite_index,
    output sprite_address, line_overflow,
    output scan_busy
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the sprite table
// into a pending slot set and resolves active slots per pixel.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int SLOTS       = 4
) (
  input  logic clk,
  input  logic reset,
  sprite_line_scheduler_if.slave bus
);
  localparam int IW = (NUM_SPRITES > 1) ?
                      $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    SCAN
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    logic [7:0]    x;
    logic [3:0]    row;
  } slot_t;

  state_t state_q, state_d;

  logic [7:0]             x_q [NUM_SPRITES];
  logic [7:0]             y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] en_q;

  slot_t         pend_q [SLOTS];
  slot_t         act_q  [SLOTS];
  logic [CW-1:0] pcnt_q;
  logic          pend_ovf_q;
  logic          ovf_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    tgt_q;

  logic          commit;
  logic          scan_step;

  logic          hit_d, hit_q;
  logic [IW-1:0] sidx_d, sidx_q;
  logic [7:0]    saddr_d, saddr_q;
  logic [7:0]    dx;

  logic [3:0] wr_ent;
  logic       wr_mask;
  logic       wr_ent_ok;

  assign wr_ent    = bus.cpu_addr[4:1];
  assign wr_mask   = bus.cpu_we &&
                     (bus.cpu_addr == 5'h1f);
  assign wr_ent_ok = bus.cpu_we && !wr_mask &&
                     ({1'b0, wr_ent} < 5'(NUM_SPRITES));

  // Live table read for the entry being scanned.
  logic [7:0] dy;
  logic       match;
  assign dy    = tgt_q - y_q[idx_q];
  assign match = en_q[idx_q] && (dy < 8'd16);

  // CPU-programmed sprite table and enable mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NUM_SPRITES; e++) begin
        x_q[e] <= '0;
        y_q[e] <= '0;
      end
      en_q <= '0;
    end else if (wr_mask) begin
      en_q <= NUM_SPRITES'(bus.cpu_data);
    end else if (wr_ent_ok) begin
      for (int e = 0; e < NUM_SPRITES; e++) begin
        if (4'(e) == wr_ent) begin
          if (bus.cpu_addr[0]) y_q[e] <= bus.cpu_data;
          else                 x_q[e] <= bus.cpu_data;
        end
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; a line_start mid-scan aborts into COMMIT.
  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    scan_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.line_start) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        if (bus.line_start) begin
          state_d = COMMIT;
        end else begin
          scan_step = 1'b1;
          if (idx_q == LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending/active slot sets and the scan cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        pend_q[s] <= '0;
        act_q[s]  <= '0;
      end
      pcnt_q     <= '0;
      pend_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      tgt_q      <= '0;
    end else if (commit) begin
      for (int s = 0; s < SLOTS; s++) begin
        act_q[s]  <= pend_q[s];
        pend_q[s] <= '0;
      end
      ovf_q      <= pend_ovf_q;
      pend_ovf_q <= 1'b0;
      pcnt_q     <= '0;
      idx_q      <= '0;
      tgt_q      <= bus.raster_y + 8'd1;
    end else if (scan_step) begin
      if (match) begin
        if (pcnt_q < CW'(SLOTS)) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (CW'(s) == pcnt_q) begin
              pend_q[s] <= '{valid: 1'b1,
                             idx:   idx_q,
                             x:     x_q[idx_q],
                             row:   dy[3:0]};
            end
          end
          pcnt_q <= pcnt_q + CW'(1);
        end else begin
          pend_ovf_q <= 1'b1;
        end
      end
      idx_q <= idx_q + IW'(1);
    end
  end

  // Pixel resolve; lowest slot wins, so scan high to low.
  always_comb begin
    hit_d   = 1'b0;
    sidx_d  = '0;
    saddr_d = '0;
    dx      = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      dx = bus.raster_x - act_q[s].x;
      if (act_q[s].valid && (dx < 8'd16)) begin
        hit_d   = 1'b1;
        sidx_d  = act_q[s].idx;
        saddr_d = {act_q[s].row, dx[3:0]};
      end
    end
  end

  // Registered pixel outputs, one cycle behind raster_x.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= 1'b0;
      sidx_q  <= '0;
      saddr_q <= '0;
    end else begin
      hit_q   <= hit_d;
      sidx_q  <= sidx_d;
      saddr_q <= saddr_d;
    end
  end

  assign bus.sprite_active  = hit_q;
  assign bus.sprite_index   = sidx_q;
  assign bus.sprite_address = saddr_q;
  assign bus.line_overflow  = ovf_q;
  assign bus.scan_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: vector table
// of pixel probes plus hand-written line sequences.
module tb_sprite_line_scheduler;
  logic clk = 1'b0;
  logic reset;

  sprite_line_scheduler_if #(.IW(3)) bus ();

  sprite_line_scheduler #(
    .NUM_SPRITES(8),
    .SLOTS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sc;
    int rx;
    int act;
    int idx;
    int addr;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic add(input int sc, input int rx,
                     input int act, input int idx,
                     input int addr);
    vec_t v;
    v.sc = sc; v.rx = rx; v.act = act;
    v.idx = idx; v.addr = addr;
    tv.push_back(v);
  endtask

  task automatic wr(input int a, input int d);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 5'(a);
    bus.cpu_data = 8'(d);
    tick();
    bus.cpu_we   = 1'b0;
  endtask

  task automatic place(input int i, input int x,
                       input int y);
    wr(2 * i, x);
    wr(2 * i + 1, y);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic new_line(input int y, output int n);
    bus.raster_y   = 8'(y);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    n = 0;
    while (bus.scan_busy === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    if (n >= 30) begin
      errors++;
      $display("FAIL scan_timeout: busy %0d cycles", n);
    end
  endtask

  task automatic sweep(output int cnt);
    cnt = 0;
    for (int x = 0; x < 256; x++) begin
      bus.raster_x = 8'(x);
      tick();
      if (bus.sprite_active === 1'b1) cnt++;
    end
  endtask

  task automatic run_vecs(input int sc);
    foreach (tv[i]) begin
      if (tv[i].sc == sc) begin
        bus.raster_x = 8'(tv[i].rx);
        tick();
        chk($sformatf("s%0d_x%0d_act", sc, tv[i].rx),
            32'(bus.sprite_active), 32'(tv[i].act));
        chk($sformatf("s%0d_x%0d_idx", sc, tv[i].rx),
            32'(bus.sprite_index), 32'(tv[i].idx));
        chk($sformatf("s%0d_x%0d_addr", sc, tv[i].rx),
            32'(bus.sprite_address), 32'(tv[i].addr));
      end
    end
  endtask

  initial begin
    int n;
    int cnt;

    add(1, 39, 0, 0, 8'h00);
    add(1, 40, 1, 2, 8'h00);
    add(1, 47, 1, 2, 8'h07);
    add(1, 55, 1, 2, 8'h0F);
    add(1, 56, 0, 0, 8'h00);
    add(2, 40, 1, 2, 8'hF0);
    add(2, 55, 1, 2, 8'hFF);
    add(3, 99, 0, 0, 8'h00);
    add(3, 100, 1, 1, 8'h00);
    add(3, 107, 1, 1, 8'h07);
    add(3, 108, 1, 1, 8'h08);
    add(3, 115, 1, 1, 8'h0F);
    add(3, 116, 1, 5, 8'h08);
    add(3, 123, 1, 5, 8'h0F);
    add(3, 124, 0, 0, 8'h00);
    add(4, 0, 1, 0, 8'h00);
    add(4, 20, 1, 1, 8'h00);
    add(4, 35, 1, 1, 8'h0F);
    add(4, 40, 1, 2, 8'h00);
    add(4, 60, 1, 3, 8'h00);
    add(4, 80, 0, 0, 8'h00);
    add(4, 100, 0, 0, 8'h00);
    add(5, 249, 0, 0, 8'h00);
    add(5, 250, 1, 0, 8'h60);
    add(5, 255, 1, 0, 8'h65);
    add(5, 0, 1, 0, 8'h66);
    add(5, 9, 1, 0, 8'h6F);
    add(5, 10, 0, 0, 8'h00);
    add(6, 0, 1, 0, 8'h00);
    add(6, 40, 1, 1, 8'h00);
    add(6, 80, 0, 0, 8'h00);
    add(6, 120, 0, 0, 8'h00);
    add(7, 80, 1, 2, 8'h00);
    add(7, 120, 1, 3, 8'h00);
    add(8, 0, 1, 0, 8'h00);
    add(8, 15, 1, 0, 8'h0F);
    add(8, 16, 0, 0, 8'h00);

    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.line_start = 1'b0;
    bus.raster_x = '0;
    bus.raster_y = '0;

    // Reset state and an empty table.
    do_reset();
    chk("rst_act", 32'(bus.sprite_active), 0);
    chk("rst_idx", 32'(bus.sprite_index), 0);
    chk("rst_addr", 32'(bus.sprite_address), 0);
    chk("rst_ovf", 32'(bus.line_overflow), 0);
    chk("rst_busy", 32'(bus.scan_busy), 0);
    new_line(9, n);
    chk("idle_busy_cycles", 32'(n), 9);
    new_line(10, n);
    sweep(cnt);
    chk("idle_hits", 32'(cnt), 0);
    chk("idle_ovf", 32'(bus.line_overflow), 0);

    // Single sprite, first and last rows.
    place(2, 40, 10);
    wr(5'h1f, 8'h04);
    new_line(9, n);
    new_line(10, n);
    run_vecs(1);
    sweep(cnt);
    chk("single_hits", 32'(cnt), 16);
    new_line(24, n);
    new_line(25, n);
    run_vecs(2);
    new_line(26, n);
    sweep(cnt);
    chk("single_gone", 32'(cnt), 0);

    // Overlap priority.
    do_reset();
    place(1, 100, 50);
    place(5, 108, 50);
    wr(5'h1f, 8'h22);
    new_line(49, n);
    new_line(50, n);
    run_vecs(3);

    // Overflow: six sprites, four slots.
    do_reset();
    for (int i = 0; i < 6; i++) place(i, 20 * i, 80);
    wr(5'h1f, 8'h3F);
    new_line(79, n);
    new_line(80, n);
    chk("ovf_set", 32'(bus.line_overflow), 1);
    run_vecs(4);
    new_line(95, n);
    new_line(96, n);
    chk("ovf_clear", 32'(bus.line_overflow), 0);

    // Vertical and horizontal wrap.
    do_reset();
    place(0, 250, 250);
    wr(5'h1f, 8'h01);
    new_line(255, n);
    new_line(0, n);
    run_vecs(5);
    sweep(cnt);
    chk("wrap_hits", 32'(cnt), 16);

    // Abort after entries 0 and 1 have been scanned.
    do_reset();
    for (int i = 0; i < 4; i++) place(i, 40 * i, 30);
    wr(5'h1f, 8'h0F);
    bus.raster_y   = 8'd29;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy", 32'(bus.scan_busy), 1);
    new_line(29, n);
    chk("abort_rescan_cycles", 32'(n), 9);
    run_vecs(6);
    new_line(29, n);
    run_vecs(7);

    // Reset mid-line beats line_start and cpu_we.
    bus.raster_x = 8'd0;
    tick();
    chk("pre_rst_act", 32'(bus.sprite_active), 1);
    reset = 1'b1;
    bus.line_start = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 5'h1f;
    bus.cpu_data = 8'hFF;
    tick();
    chk("midrst_act", 32'(bus.sprite_active), 0);
    chk("midrst_busy", 32'(bus.scan_busy), 0);
    reset = 1'b0;
    bus.line_start = 1'b0;
    bus.cpu_we = 1'b0;
    tick();
    chk("postrst_busy", 32'(bus.scan_busy), 0);
    new_line(255, n);
    new_line(0, n);
    sweep(cnt);
    chk("postrst_mask_off", 32'(cnt), 0);
    wr(5'h1f, 8'h0F);
    sweep(cnt);
    chk("reenable_hidden", 32'(cnt), 0);
    new_line(255, n);
    sweep(cnt);
    chk("scan_not_committed", 32'(cnt), 0);
    new_line(0, n);
    run_vecs(8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
